// File: rtl/q_requant_pkg.sv
// rtl/q_requant_pkg.sv - shared types and geometry for the FP32 -> INT8 Q requantiser
package q_requant_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SRC_WORDS     = 128;
  localparam int LANES         = 4;
  localparam int WORDS_PER_DST = 4;
  localparam int DST_WORDS     = SRC_WORDS / WORDS_PER_DST;
  localparam int SRC_AW        = 7;
  localparam int DST_AW        = 5;
  localparam int WORD_W        = 128;

  function automatic logic [2:0] clip_count(input logic [LANES-1:0] c);
    return {2'b00, c[0]} + {2'b00, c[1]} + {2'b00, c[2]} + {2'b00, c[3]};
  endfunction

endpackage

// File: rtl/q_requant_if.sv
// rtl/q_requant_if.sv - source (FP32 tile) and destination (INT8 pack) memory ports
interface q_requant_if;
  import q_requant_pkg::*;

  logic [WORD_W-1:0] SRC_MEM_DOUT;
  logic              SRC_MEM_CEB;
  logic              SRC_MEM_WEN;
  logic [SRC_AW-1:0] SRC_MEM_ADDR;
  logic [WORD_W-1:0] DST_MEM_DIN;
  logic              DST_MEM_CEB;
  logic              DST_MEM_WEN;
  logic [DST_AW-1:0] DST_MEM_ADDR;

  modport master (
    input  SRC_MEM_DOUT,
    output SRC_MEM_CEB, SRC_MEM_WEN, SRC_MEM_ADDR,
    output DST_MEM_DIN, DST_MEM_CEB, DST_MEM_WEN, DST_MEM_ADDR
  );

  modport slave (
    output SRC_MEM_DOUT,
    input  SRC_MEM_CEB, SRC_MEM_WEN, SRC_MEM_ADDR,
    input  DST_MEM_DIN, DST_MEM_CEB, DST_MEM_WEN, DST_MEM_ADDR
  );

endinterface

// File: rtl/q_requant_fp32_to_int8_sat.sv
// rtl/q_requant_fp32_to_int8_sat.sv - combinational FP32 * 2^SCALE_EXP -> saturated INT8, round half away from zero
module fp32_to_int8_sat #(
  parameter int SCALE_EXP = 4
) (
  input  logic [31:0] x,
  output logic [7:0]  q,
  output logic        clipped
);

  logic              sign;
  logic [7:0]        expo;
  logic [23:0]       mant;
  logic signed [10:0] sh;
  logic [4:0]        rsh;
  logic [9:0]        t;
  logic [9:0]        mag;

  // sh is the binary weight of the hidden bit after scaling; t keeps one fraction bit for rounding
  always_comb begin
    sign    = x[31];
    expo    = x[30:23];
    mant    = {1'b1, x[22:0]};
    sh      = $signed({3'b000, expo}) - 11'sd127 + 11'(SCALE_EXP);
    rsh     = 5'd0;
    t       = 10'd0;
    mag     = 10'd0;
    q       = 8'd0;
    clipped = 1'b0;
    if (expo == 8'hff) begin
      clipped = 1'b1;
      if (x[22:0] == 23'd0) begin
        q = sign ? 8'h80 : 8'h7f;
      end
    end else if (expo == 8'h00) begin
      q = 8'd0;
    end else if (sh >= 11'sd8) begin
      clipped = 1'b1;
      q       = sign ? 8'h80 : 8'h7f;
    end else if (sh >= -11'sd1) begin
      rsh = 5'(11'sd22 - sh);
      t   = 10'(mant >> rsh);
      mag = {1'b0, t[9:1]} + {9'd0, t[0]};
      if (!sign && mag > 10'd127) begin
        clipped = 1'b1;
        q       = 8'h7f;
      end else if (sign && mag > 10'd128) begin
        clipped = 1'b1;
        q       = 8'h80;
      end else begin
        q = sign ? 8'(10'd0 - mag) : mag[7:0];
      end
    end
  end

endmodule

// File: rtl/q_requant.sv
// rtl/q_requant.sv - Q tile requantiser top; Q_REQUANT_SAT_CNT_EN enables the clip counter on sat_count
module q_requant
  import q_requant_pkg::*;
#(
  parameter int SCALE_EXP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        busy,
  output logic        valid,
  output logic [7:0]  sat_count,
  q_requant_if.master mem
);

  state_t state, state_nxt;

  logic              src_ceb;
  logic [SRC_AW-1:0] src_addr;
  logic              rd_vld;
  logic [SRC_AW-1:0] rd_idx;
  logic [95:0]       pack_q;
  logic [WORD_W-1:0] dst_din;
  logic              dst_ceb;
  logic              dst_wen;
  logic [DST_AW-1:0] dst_addr;
  logic [LANES*8-1:0] cvt_word;
  logic [LANES-1:0]  lane_clip;

  for (genvar j = 0; j < LANES; j++) begin : g_cvt
    fp32_to_int8_sat #(.SCALE_EXP(SCALE_EXP)) u_cvt (
      .x       (mem.SRC_MEM_DOUT[j*32 +: 32]),
      .q       (cvt_word[j*8 +: 8]),
      .clipped (lane_clip[j])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (src_addr == SRC_AW'(SRC_WORDS - 1)) state_nxt = DRAIN;
      DRAIN:   if (!dst_ceb && dst_addr == DST_AW'(DST_WORDS - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy  = (state == RUN) || (state == DRAIN);
  assign valid = (state == DONE);

  // Slot 3 goes straight into the write word so the DST write lands the cycle after its read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_ceb  <= 1'b1;
      src_addr <= '0;
      rd_vld   <= 1'b0;
      rd_idx   <= '0;
      pack_q   <= '0;
      dst_din  <= '0;
      dst_ceb  <= 1'b1;
      dst_wen  <= 1'b1;
      dst_addr <= '0;
    end else begin
      src_ceb <= (state_nxt != RUN);
      if (state_nxt == RUN) begin
        src_addr <= (state == RUN) ? src_addr + SRC_AW'(1) : '0;
      end
      rd_vld  <= !src_ceb;
      rd_idx  <= src_addr;
      dst_ceb <= 1'b1;
      dst_wen <= 1'b1;
      if (rd_vld) begin
        if (rd_idx[1:0] == 2'd3) begin
          dst_din  <= {cvt_word, pack_q};
          dst_addr <= rd_idx[SRC_AW-1:2];
          dst_ceb  <= 1'b0;
          dst_wen  <= 1'b0;
        end else begin
          pack_q[{rd_idx[1:0], 5'b00000} +: 32] <= cvt_word;
        end
      end
    end
  end

  assign mem.SRC_MEM_CEB  = src_ceb;
  assign mem.SRC_MEM_WEN  = 1'b1;
  assign mem.SRC_MEM_ADDR = src_addr;
  assign mem.DST_MEM_DIN  = dst_din;
  assign mem.DST_MEM_CEB  = dst_ceb;
  assign mem.DST_MEM_WEN  = dst_wen;
  assign mem.DST_MEM_ADDR = dst_addr;

`ifdef Q_REQUANT_SAT_CNT_EN
  logic [7:0] sat_cnt_q;
  logic [8:0] sat_sum;

  always_comb begin
    sat_sum = {1'b0, sat_cnt_q} + {6'd0, clip_count(lane_clip)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt_q <= 8'd0;
    end else if (state == IDLE && state_nxt == RUN) begin
      sat_cnt_q <= 8'd0;
    end else if (rd_vld) begin
      sat_cnt_q <= sat_sum[8] ? 8'hff : sat_sum[7:0];
    end
  end

  assign sat_count = sat_cnt_q;
`else
  logic clip_unused;
  assign clip_unused = |lane_clip;
  assign sat_count   = 8'd0;
`endif

endmodule

// File: tb/tb_q_requant.sv
// tb/tb_q_requant.sv - scoreboard bench for q_requant: timing, conversion, restart and reset behaviour
module tb_q_requant;
  import q_requant_pkg::*;

  localparam int SCALE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       busy;
  logic       valid;
  logic [7:0] sat_count;

  q_requant_if mem_if ();

  q_requant #(.SCALE_EXP(SCALE)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .busy      (busy),
    .valid     (valid),
    .sat_count (sat_count),
    .mem       (mem_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [4:0]   addr;
    logic [127:0] data;
  } exp_t;

  logic [127:0] src_mem [SRC_WORDS];
  logic [127:0] dst_mem [DST_WORDS];
  exp_t         exp_q [$];
  exp_t         mon_e;
  int cyc = 0;
  int src_reads = 0;
  int reads0 = 0;
  int n_checks = 0;
  int n_errors = 0;
  int exp_valid_cyc = -1;
  int exp_sat = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Real-valued reference: scale, then round half away from zero via floor(|r|+0.5)
  function automatic logic [8:0] ref_cvt(input logic [31:0] x);
    int  e;
    int  qi;
    real r;
    e = int'(x[30:23]);
    if (e == 255) return (x[22:0] == 23'd0) ? {1'b1, (x[31] ? 8'h80 : 8'h7f)} : 9'h100;
    if (e == 0) return 9'h000;
    r = 1.0 + real'(x[22:0]) / 8388608.0;
    e = e - 127 + SCALE;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    if (!x[31] && r >= 127.5) return 9'h17f;
    if (x[31] && r >= 128.5) return 9'h180;
    qi = int'($floor(r + 0.5));
    if (x[31]) qi = -qi;
    return {1'b0, 8'(qi)};
  endfunction

  function automatic logic [31:0] ramp_fp(input int s);
    int          p;
    logic [31:0] m;
    if (s == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 8; i++) if (s[i]) p = i;
    m = 32'(s) << (23 - p);
    return {1'b0, 8'(127 + p - 4), m[22:0]};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_if.SRC_MEM_CEB) begin
      mem_if.SRC_MEM_DOUT <= src_mem[mem_if.SRC_MEM_ADDR];
      src_reads <= src_reads + 1;
    end
    if (!mem_if.DST_MEM_CEB && !mem_if.DST_MEM_WEN)
      dst_mem[mem_if.DST_MEM_ADDR] <= mem_if.DST_MEM_DIN;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (!mem_if.DST_MEM_CEB || !mem_if.DST_MEM_WEN) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", cyc, -1);
        end else begin
          mon_e = exp_q.pop_front();
          check("dst_cycle", cyc, mon_e.cyc);
          check("dst_addr", mem_if.DST_MEM_ADDR, mon_e.addr);
          check("dst_data", mem_if.DST_MEM_DIN, mon_e.data);
          check("dst_wen_ceb", {mem_if.DST_MEM_CEB, mem_if.DST_MEM_WEN}, 2'b00);
        end
      end
      if (valid) check("valid_cycle", cyc, exp_valid_cyc);
    end
  end

  // Called at a negedge in cycle 0; returns at the negedge of cycle 1
  task automatic start_run();
    exp_t        e;
    logic [8:0]  b;
    int          clips;
    clips = 0;
    for (int w = 0; w < DST_WORDS; w++) begin
      e.cyc  = cyc + 4 * w + 6;
      e.addr = 5'(w);
      e.data = '0;
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < LANES; j++) begin
          b = ref_cvt(src_mem[4 * w + k][j * 32 +: 32]);
          e.data[(k * 4 + j) * 8 +: 8] = b[7:0];
          clips += int'(b[8]);
        end
      end
      exp_q.push_back(e);
    end
`ifdef Q_REQUANT_SAT_CNT_EN
    exp_sat = (clips > 255) ? 255 : clips;
`else
    exp_sat = 0;
`endif
    exp_valid_cyc = cyc + 131;
    reads0 = src_reads;
    check("busy_c0", busy, 1'b0);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check("busy_c1", busy, 1'b1);
  endtask

  // Called at cycle 130; returns at cycle 132
  task automatic finish_run(input bit pulse_at_done);
    check("busy_c130", busy, 1'b1);
    @(negedge clk);
    check("busy_c131", busy, 1'b0);
    check("valid_c131", valid, 1'b1);
    if (pulse_at_done) en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check("valid_c132", valid, 1'b0);
    check("pending_writes", exp_q.size(), 0);
    check("src_reads", src_reads - reads0, SRC_WORDS);
    check("sat_count", sat_count, exp_sat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_valid"}, valid, 1'b0);
    check({tag, "_src_ceb_wen"}, {mem_if.SRC_MEM_CEB, mem_if.SRC_MEM_WEN}, 2'b11);
    check({tag, "_src_addr"}, mem_if.SRC_MEM_ADDR, 7'd0);
    check({tag, "_dst_ceb_wen"}, {mem_if.DST_MEM_CEB, mem_if.DST_MEM_WEN}, 2'b11);
    check({tag, "_dst_addr"}, mem_if.DST_MEM_ADDR, 5'd0);
    check({tag, "_dst_din"}, mem_if.DST_MEM_DIN, 128'd0);
    check({tag, "_sat"}, sat_count, 8'd0);
  endtask

  task automatic load_mixed();
    logic [31:0] lane;
    src_mem[0] = {32'h00000000, 32'hC0220000, 32'h40220000, 32'h3F800000};
    src_mem[1] = {32'h7FC00000, 32'h7F800000, 32'hC2C80000, 32'h42C80000};
    src_mem[2] = {32'hC1008000, 32'h40FF0000, 32'h80000000, 32'h000116C2};
    src_mem[3] = {32'hC1000000, 32'h3F000000, 32'hBD000000, 32'h3D000000};
    for (int s = 4; s < SRC_WORDS; s++) begin
      for (int j = 0; j < LANES; j++) begin
        lane = {1'($urandom_range(0, 1)), 8'($urandom_range(116, 136)), 23'($urandom)};
        if ($urandom_range(0, 1) == 1) lane[11:0] = 12'd0;
        src_mem[s][j * 32 +: 32] = lane;
      end
    end
  endtask

  initial begin
    load_mixed();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_init");
    rst = 1'b0;
    @(negedge clk);

    start_run();
    repeat (129) @(negedge clk);
    finish_run(1'b0);
    check("vec_w0_lanes", dst_mem[0][31:0], 32'h00D72910);
    check("vec_w1_special", dst_mem[0][63:32], 32'h007F807F);
    check("vec_w2_denorm_thresh", dst_mem[0][95:64], 32'h807F0000);
    check("vec_w3_ties", dst_mem[0][127:96], 32'h8008FF01);

    for (int s = 0; s < SRC_WORDS; s++) begin
      for (int j = 0; j < LANES; j++) src_mem[s][j * 32 +: 32] = ramp_fp(s);
    end
    start_run();
    repeat (49) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (79) @(negedge clk);
    finish_run(1'b1);
    start_run();
    repeat (129) @(negedge clk);
    finish_run(1'b0);
    for (int w = 0; w < DST_WORDS; w += 5) begin
      for (int b = 0; b < 16; b += 5) check("ramp_byte", dst_mem[w][b * 8 +: 8], 8'(4 * w + b / 4));
    end

    load_mixed();
    start_run();
    repeat (59) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    exp_q.delete();
    exp_valid_cyc = -1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    start_run();
    repeat (129) @(negedge clk);
    finish_run(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
